// File: rtl/cpu_dmem_responder_if.sv
// Execute-stage dmem bus: Wishbone classic, 32-bit byte address, 16-bit data, two byte lanes.
interface cpu_dmem_responder_if;
    logic [31:0] address;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        stb;
    logic        cyc;
    logic        we;
    logic [1:0]  sel;
    logic        ack;
    logic        err;

    modport master (
        output address, wdata, stb, cyc, we, sel,
        input  rdata, ack, err
    );

    modport slave (
        input  address, wdata, stb, cyc, we, sel,
        output rdata, ack, err
    );
endinterface

// File: rtl/cpu_dmem_responder.sv
// Wishbone classic slave that answers the dmem bus from an on-chip 16-bit data RAM,
// with programmable wait states, byte-lane writes and error termination.
module cpu_dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic                  clk_i,
    input logic                  rst_i,
    cpu_dmem_responder_if.slave  dmem
);

    localparam int unsigned IdxW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] WindowBytes = 33'(DEPTH) << 1;
    localparam logic [3:0]  CntLoad     = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            we_q, we_d;
    logic [1:0]      sel_q, sel_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            dec_err_q, dec_err_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [15:0]     rdata_q, rdata_d;

    logic            req;
    logic [31:0]     offset;
    logic            dec_err;
    logic [IdxW-1:0] dec_idx;
    logic            enter_resp;
    logic            mem_we;

    logic [15:0]     mem [DEPTH];

    // Address decode on the live bus; only used at the request edge.
    always_comb begin
        req     = dmem.cyc & dmem.stb;
        offset  = dmem.address - BASE_ADDR;
        dec_err = dmem.address[0] | (dmem.address < BASE_ADDR) | ({1'b0, offset} >= WindowBytes);
        dec_idx = offset[IdxW:1];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        we_d       = we_q;
        sel_d      = sel_q;
        wdata_d    = wdata_q;
        dec_err_d  = dec_err_q;
        enter_resp = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    idx_d     = dec_idx;
                    we_d      = dmem.we;
                    sel_d     = dmem.sel;
                    wdata_d   = dmem.wdata;
                    dec_err_d = dec_err;
                    if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = CntLoad;
                    end else begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end
                end
            end
            StWait: begin
                if (!req) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // The _d copies hold the transfer attributes both on a zero-wait request and in WAIT.
    always_comb begin
        ack_d   = enter_resp & ~dec_err_d;
        err_d   = enter_resp & dec_err_d;
        mem_we  = enter_resp & we_d & ~dec_err_d;
        rdata_d = (enter_resp & ~we_d & ~dec_err_d) ? mem[idx_d] : 16'h0000;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= 2'b00;
            wdata_q   <= 16'h0000;
            dec_err_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            dec_err_q <= dec_err_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    // RAM is never cleared; reset only blocks a write that would coincide with it.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            if (sel_d[0]) mem[idx_d][7:0]  <= wdata_d[7:0];
            if (sel_d[1]) mem[idx_d][15:8] <= wdata_d[15:8];
        end
    end

    assign dmem.ack   = ack_q;
    assign dmem.err   = err_q;
    assign dmem.rdata = rdata_q;

endmodule

// File: tb/tb_cpu_dmem_responder.sv
// Randomized bench for cpu_dmem_responder: a zero-wait and a three-wait instance checked
// against a word/byte-lane memory model.
module tb_cpu_dmem_responder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned DEPTH = 64;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic [15:0] model [2][DEPTH];

    cpu_dmem_responder_if bus0();
    cpu_dmem_responder_if bus3();

    cpu_dmem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .dmem  (bus0)
    );

    cpu_dmem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(3)) u_dut3 (
        .clk_i (clk),
        .rst_i (rst),
        .dmem  (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int waits(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic bit exp_err(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (a[0] == 1'b1) || (la < longint'(BASE)) || ((la - longint'(BASE)) >= 2 * DEPTH);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 2);
    endfunction

    task automatic model_write(input int k, input logic [31:0] a, input logic [1:0] s,
                               input logic [15:0] d);
        int i;
        i = word_of(a);
        if (s[0]) model[k][i][7:0]  = d[7:0];
        if (s[1]) model[k][i][15:8] = d[15:8];
    endtask

    task automatic drive(input int k, input logic [31:0] a, input logic w, input logic [1:0] s,
                         input logic [15:0] d, input logic act);
        if (k == 0) begin
            bus0.address = a; bus0.we = w; bus0.sel = s; bus0.wdata = d;
            bus0.cyc = act; bus0.stb = act;
        end else begin
            bus3.address = a; bus3.we = w; bus3.sel = s; bus3.wdata = d;
            bus3.cyc = act; bus3.stb = act;
        end
    endtask

    task automatic sample(input int k, output logic a, output logic e, output logic [15:0] q);
        if (k == 0) begin
            a = bus0.ack; e = bus0.err; q = bus0.rdata;
        end else begin
            a = bus3.ack; e = bus3.err; q = bus3.rdata;
        end
    endtask

    // One full transfer; lat=0 means no termination within the cycle budget.
    task automatic xfer(input int k, input logic [31:0] a, input logic w, input logic [1:0] s,
                        input logic [15:0] d, output logic ack, output logic err,
                        output logic [15:0] q, output int lat, output logic gap_ok);
        logic sa, se;
        logic [15:0] sq;
        ack = 1'b0; err = 1'b0; q = 16'h0; lat = 0;
        drive(k, a, w, s, d, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            sample(k, sa, se, sq);
            if (sa || se) begin
                ack = sa; err = se; q = sq; lat = i;
                break;
            end
        end
        drive(k, 32'h0, 1'b0, 2'b00, 16'h0, 1'b0);
        @(negedge clk);
        sample(k, sa, se, sq);
        gap_ok = !(sa || se);
    endtask

    task automatic test_reset();
        logic a, e;
        logic [15:0] q;
        rst = 1'b1;
        drive(0, 32'h0, 1'b0, 2'b00, 16'h0, 1'b0);
        drive(1, 32'h0, 1'b0, 2'b00, 16'h0, 1'b0);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sample(k, a, e, q);
            checks++;
            if (a !== 1'b0) begin errors++; $display("FAIL reset_ack dut%0d: got %b want 0", k, a); end
            checks++;
            if (e !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d: got %b want 0", k, e); end
            checks++;
            if (q !== 16'h0) begin errors++; $display("FAIL reset_data dut%0d: got %h want 0", k, q); end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill();
        logic a, e, g;
        logic [15:0] q, d;
        int lat;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                d = 16'($urandom);
                xfer(k, BASE + 32'(2 * i), 1'b1, 2'b11, d, a, e, q, lat, g);
                model_write(k, BASE + 32'(2 * i), 2'b11, d);
                checks++;
                if (a !== 1'b1 || e !== 1'b0 || lat != waits(k) + 1) begin
                    errors++;
                    $display("FAIL fill dut%0d word %0d: ack=%b err=%b lat=%0d want ack=1 err=0 lat=%0d",
                             k, i, a, e, lat, waits(k) + 1);
                end
            end
        end
    endtask

    task automatic test_basic();
        logic a, e, g;
        logic [15:0] q;
        int lat;
        xfer(0, BASE + 4, 1'b1, 2'b11, 16'h1234, a, e, q, lat, g);
        model_write(0, BASE + 4, 2'b11, 16'h1234);
        checks++;
        if (a !== 1'b1 || e !== 1'b0 || lat != 1 || g !== 1'b1) begin
            errors++;
            $display("FAIL basic_write: ack=%b err=%b lat=%0d gap=%b want 1 0 1 1", a, e, lat, g);
        end
        xfer(0, BASE + 4, 1'b0, 2'b11, 16'h0, a, e, q, lat, g);
        checks++;
        if (a !== 1'b1 || lat != 1 || q !== 16'h1234) begin
            errors++;
            $display("FAIL basic_read: ack=%b lat=%0d data=%h want 1 1 1234", a, lat, q);
        end
    endtask

    task automatic test_lanes();
        logic a, e, g;
        logic [15:0] q;
        int lat;
        xfer(0, BASE + 4, 1'b1, 2'b01, 16'h00AB, a, e, q, lat, g);
        model_write(0, BASE + 4, 2'b01, 16'h00AB);
        xfer(0, BASE + 4, 1'b0, 2'b00, 16'h0, a, e, q, lat, g);
        checks++;
        if (q !== 16'h12AB) begin errors++; $display("FAIL lane_low: got %h want 12ab", q); end
        xfer(0, BASE + 4, 1'b1, 2'b10, 16'hCD00, a, e, q, lat, g);
        model_write(0, BASE + 4, 2'b10, 16'hCD00);
        xfer(0, BASE + 4, 1'b0, 2'b01, 16'h0, a, e, q, lat, g);
        checks++;
        if (q !== 16'hCDAB) begin errors++; $display("FAIL lane_high: got %h want cdab", q); end
        xfer(0, BASE + 4, 1'b1, 2'b00, 16'hFFFF, a, e, q, lat, g);
        checks++;
        if (a !== 1'b1 || e !== 1'b0) begin
            errors++; $display("FAIL sel00_ack: ack=%b err=%b want 1 0", a, e);
        end
        xfer(0, BASE + 4, 1'b0, 2'b11, 16'h0, a, e, q, lat, g);
        checks++;
        if (q !== 16'hCDAB) begin errors++; $display("FAIL sel00_data: got %h want cdab", q); end
    endtask

    task automatic test_wait_states();
        logic a, e, g;
        logic [15:0] q;
        int lat;
        xfer(1, BASE + 4, 1'b1, 2'b11, 16'h1234, a, e, q, lat, g);
        model_write(1, BASE + 4, 2'b11, 16'h1234);
        checks++;
        if (a !== 1'b1 || e !== 1'b0 || lat != 4 || g !== 1'b1) begin
            errors++;
            $display("FAIL wait_write: ack=%b err=%b lat=%0d gap=%b want 1 0 4 1", a, e, lat, g);
        end
        xfer(1, BASE + 4, 1'b0, 2'b11, 16'h0, a, e, q, lat, g);
        checks++;
        if (a !== 1'b1 || lat != 4 || q !== 16'h1234) begin
            errors++;
            $display("FAIL wait_read: ack=%b lat=%0d data=%h want 1 4 1234", a, lat, q);
        end
    endtask

    task automatic test_errors();
        logic a, e, g;
        logic [15:0] q;
        int lat;
        logic [31:0] bad [3];
        bad[0] = BASE + 32'(2 * DEPTH);
        bad[1] = BASE + 5;
        bad[2] = BASE - 2;
        for (int k = 0; k < 2; k++) begin
            for (int b = 0; b < 3; b++) begin
                xfer(k, bad[b], (b != 0), 2'b11, 16'hFFFF, a, e, q, lat, g);
                checks++;
                if (a !== 1'b0 || e !== 1'b1 || q !== 16'h0 || lat != waits(k) + 1 || g !== 1'b1) begin
                    errors++;
                    $display("FAIL err_resp dut%0d addr %h: ack=%b err=%b data=%h lat=%0d want 0 1 0000 %0d",
                             k, bad[b], a, e, q, lat, waits(k) + 1);
                end
            end
            xfer(k, BASE + 4, 1'b0, 2'b11, 16'h0, a, e, q, lat, g);
            checks++;
            if (q !== model[k][2]) begin
                errors++; $display("FAIL err_ram dut%0d: got %h want %h", k, q, model[k][2]);
            end
        end
    endtask

    task automatic test_random();
        logic a, e, g, w, ee;
        logic [15:0] q, d;
        logic [1:0] s;
        logic [31:0] adr;
        int lat, k, r;
        for (int n = 0; n < 80; n++) begin
            k = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            case (r)
                0:       adr = BASE + 32'(2 * $urandom_range(0, DEPTH - 1)) + 1;
                1:       adr = BASE - 32'(2 * $urandom_range(1, 8));
                2:       adr = BASE + 32'(2 * DEPTH) + 32'(2 * $urandom_range(0, 8));
                default: adr = BASE + 32'(2 * $urandom_range(0, DEPTH - 1));
            endcase
            w  = 1'($urandom);
            s  = 2'($urandom);
            d  = 16'($urandom);
            ee = exp_err(adr);
            xfer(k, adr, w, s, d, a, e, q, lat, g);
            checks++;
            if (a !== !ee || e !== ee || lat != waits(k) + 1 || g !== 1'b1) begin
                errors++;
                $display("FAIL rand_term dut%0d addr %h: ack=%b err=%b lat=%0d gap=%b want %b %b %0d 1",
                         k, adr, a, e, lat, g, !ee, ee, waits(k) + 1);
            end
            if (ee) begin
                checks++;
                if (q !== 16'h0) begin errors++; $display("FAIL rand_errdata: got %h want 0", q); end
            end else if (w) begin
                model_write(k, adr, s, d);
            end else begin
                checks++;
                if (q !== model[k][word_of(adr)]) begin
                    errors++;
                    $display("FAIL rand_read dut%0d addr %h: got %h want %h",
                             k, adr, q, model[k][word_of(adr)]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic a, e, exp_a;
        logic [15:0] q;
        int w;
        for (int k = 0; k < 2; k++) begin
            w = waits(k);
            drive(k, BASE + 6, 1'b0, 2'b11, 16'h0, 1'b1);
            for (int i = 1; i <= 3 * (w + 2); i++) begin
                @(negedge clk);
                sample(k, a, e, q);
                exp_a = (i >= w + 1) && (((i - (w + 1)) % (w + 2)) == 0);
                checks++;
                if (a !== exp_a || e !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b dut%0d cycle %0d: ack=%b err=%b want %b 0", k, i, a, e, exp_a);
                end
                if (exp_a) begin
                    checks++;
                    if (q !== model[k][3]) begin
                        errors++; $display("FAIL b2b_data dut%0d: got %h want %h", k, q, model[k][3]);
                    end
                end
            end
            drive(k, 32'h0, 1'b0, 2'b00, 16'h0, 1'b0);
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_latched();
        logic a, e, g;
        logic [15:0] q;
        int lat;
        lat = 0;
        drive(1, BASE + 10, 1'b1, 2'b11, 16'hAAAA, 1'b1);
        @(negedge clk);
        drive(1, BASE + 20, 1'b0, 2'b00, 16'h5555, 1'b1);
        for (int i = 2; i <= 12; i++) begin
            @(negedge clk);
            sample(1, a, e, q);
            if (a || e) begin lat = i; break; end
        end
        drive(1, 32'h0, 1'b0, 2'b00, 16'h0, 1'b0);
        @(negedge clk);
        model_write(1, BASE + 10, 2'b11, 16'hAAAA);
        checks++;
        if (a !== 1'b1 || lat != 4) begin
            errors++; $display("FAIL latched_term: ack=%b lat=%0d want 1 4", a, lat);
        end
        xfer(1, BASE + 10, 1'b0, 2'b11, 16'h0, a, e, q, lat, g);
        checks++;
        if (q !== 16'hAAAA) begin errors++; $display("FAIL latched_data: got %h want aaaa", q); end
        xfer(1, BASE + 20, 1'b0, 2'b11, 16'h0, a, e, q, lat, g);
        checks++;
        if (q !== model[1][10]) begin
            errors++; $display("FAIL latched_other: got %h want %h", q, model[1][10]);
        end
    endtask

    task automatic test_abort();
        logic a, e, g, seen;
        logic [15:0] q;
        int lat;
        seen = 1'b0;
        drive(1, BASE + 12, 1'b1, 2'b11, ~model[1][6], 1'b1);
        repeat (2) @(negedge clk);
        bus3.stb = 1'b0;
        repeat (6) begin
            @(negedge clk);
            sample(1, a, e, q);
            if (a || e) seen = 1'b1;
        end
        drive(1, 32'h0, 1'b0, 2'b00, 16'h0, 1'b0);
        @(negedge clk);
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_term: got %b want 0", seen); end
        xfer(1, BASE + 12, 1'b0, 2'b11, 16'h0, a, e, q, lat, g);
        checks++;
        if (a !== 1'b1 || lat != 4 || q !== model[1][6]) begin
            errors++;
            $display("FAIL abort_after: ack=%b lat=%0d data=%h want 1 4 %h", a, lat, q, model[1][6]);
        end
    endtask

    task automatic test_reset_mid();
        logic a, e, g, seen;
        logic [15:0] q;
        int lat;
        seen = 1'b0;
        drive(1, BASE + 14, 1'b1, 2'b11, ~model[1][7], 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        drive(1, 32'h0, 1'b0, 2'b00, 16'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            sample(1, a, e, q);
            if (a || e) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_term: got %b want 0", seen); end
        xfer(1, BASE + 14, 1'b0, 2'b11, 16'h0, a, e, q, lat, g);
        checks++;
        if (q !== model[1][7]) begin
            errors++; $display("FAIL rstmid_ram: got %h want %h", q, model[1][7]);
        end
        xfer(1, BASE + 4, 1'b1, 2'b11, 16'h1234, a, e, q, lat, g);
        model_write(1, BASE + 4, 2'b11, 16'h1234);
        checks++;
        if (a !== 1'b1 || e !== 1'b0 || lat != 4) begin
            errors++; $display("FAIL rstmid_write: ack=%b err=%b lat=%0d want 1 0 4", a, e, lat);
        end
        xfer(1, BASE + 4, 1'b0, 2'b11, 16'h0, a, e, q, lat, g);
        checks++;
        if (q !== 16'h1234) begin errors++; $display("FAIL rstmid_read: got %h want 1234", q); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        drive(0, 32'h0, 1'b0, 2'b00, 16'h0, 1'b0);
        drive(1, 32'h0, 1'b0, 2'b00, 16'h0, 1'b0);
        @(negedge clk);
        test_reset();
        test_fill();
        test_basic();
        test_lanes();
        test_wait_states();
        test_errors();
        test_random();
        test_back_to_back();
        test_latched();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
